// File: rtl/icache_fetch_if.sv
// CPU fetch port and instruction-memory block-read port of icache_fetch.
// ICACHE_PERF_EN adds the hit/miss counter signals.
interface icache_fetch_if #(
  parameter int unsigned AddrW = 10
);
  logic [31:0]      pc;
  logic [31:0]      instruction;
  logic             busywait;
  logic             mem_read;
  logic [AddrW-5:0] mem_address;
  logic [127:0]     mem_readdata;
  logic             mem_busywait;
`ifdef ICACHE_PERF_EN
  logic [15:0]      hit_count;
  logic [15:0]      miss_count;

  modport master (
    input  pc, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address, hit_count, miss_count
  );
  modport slave (
    output pc, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address, hit_count, miss_count
  );
`else
  modport master (
    input  pc, mem_readdata, mem_busywait,
    output instruction, busywait, mem_read, mem_address
  );
  modport slave (
    output pc, mem_readdata, mem_busywait,
    input  instruction, busywait, mem_read, mem_address
  );
`endif
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with 4-word lines and a stalling block-fill FSM.
// Define ICACHE_PERF_EN to add saturating hit/miss counters.
module icache_fetch #(
  parameter int unsigned NumBlocks = 8,
  parameter int unsigned AddrW     = 10
) (
  input logic            clk,
  input logic            reset,
  icache_fetch_if.master bus
);

  localparam int unsigned IdxW = $clog2(NumBlocks);
  localparam int unsigned BlkW = AddrW - 4;
  localparam int unsigned TagW = BlkW - IdxW;

  typedef enum logic {StIdle, StFetch} state_e;

  state_e state_q, state_d;

  logic [NumBlocks-1:0] valid_q;
  logic [TagW-1:0]      tag_q  [NumBlocks];
  logic [127:0]         data_q [NumBlocks];

  logic            mem_read_q, mem_read_d;
  logic [BlkW-1:0] mem_address_q, mem_address_d;

  logic [1:0]      pc_off;
  logic [IdxW-1:0] pc_idx;
  logic [TagW-1:0] pc_tag;
  logic [BlkW-1:0] pc_blk;
  logic            hit;
  logic            fill_en;
  logic [IdxW-1:0] fill_idx;
  logic [TagW-1:0] fill_tag;
  logic            unused_pc;

  assign pc_off    = bus.pc[3:2];
  assign pc_idx    = bus.pc[4+IdxW-1:4];
  assign pc_tag    = bus.pc[AddrW-1:4+IdxW];
  assign pc_blk    = bus.pc[AddrW-1:4];
  assign unused_pc = ^{bus.pc[31:AddrW], bus.pc[1:0]};

  assign hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  // The fill targets the latched block address, not the current PC.
  assign fill_en  = (state_q == StFetch) && !bus.mem_busywait && !reset;
  assign fill_idx = mem_address_q[IdxW-1:0];
  assign fill_tag = mem_address_q[BlkW-1:IdxW];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      valid_q       <= '0;
      mem_read_q    <= 1'b0;
      mem_address_q <= '0;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      mem_address_q <= mem_address_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_readdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_read_d    = mem_read_q;
    mem_address_d = mem_address_q;
    unique case (state_q)
      StIdle: begin
        if (!hit) begin
          state_d       = StFetch;
          mem_read_d    = 1'b1;
          mem_address_d = pc_blk;
        end
      end
      StFetch: begin
        if (!bus.mem_busywait) begin
          state_d    = StIdle;
          mem_read_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busywait    = 1'b0;
    bus.instruction = '0;
    if (!reset) begin
      unique case (state_q)
        StIdle: begin
          bus.busywait = !hit;
          if (hit) bus.instruction = data_q[pc_idx][{pc_off, 5'b0} +: 32];
        end
        StFetch: bus.busywait = 1'b1;
        default: bus.busywait = 1'b1;
      endcase
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = mem_address_q;

`ifdef ICACHE_PERF_EN
  logic [15:0]      hit_count_q, miss_count_q;
  logic [AddrW-3:0] last_pc_q;
  logic             fill_done_q;
  logic             count_hit, count_miss;

  // A held PC counts once; the first cycle after a fill counts even if the PC did not move.
  assign count_hit  = (state_q == StIdle) && hit &&
                      ((bus.pc[AddrW-1:2] != last_pc_q) || fill_done_q);
  assign count_miss = (state_q == StIdle) && !hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      last_pc_q    <= '0;
      fill_done_q  <= 1'b0;
    end else begin
      last_pc_q   <= bus.pc[AddrW-1:2];
      fill_done_q <= fill_en;
      if (count_hit && hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
      if (count_miss && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
`endif

endmodule
